// File: rtl/des_block_scheduler_if.sv
`timescale 1ns/1ps
// Datapath bundle between the block scheduler and the input SRAM, cipher and output SRAM.
// master = scheduler side, slave = SRAM/cipher side.
interface des_block_scheduler_if #(
    parameter int ADDRSIZE  = 14,
    parameter int SRAMWIDTH = 64
);
    logic                 in_rd_en;
    logic [ADDRSIZE-1:0]  in_rd_addr;
    logic [SRAMWIDTH-1:0] in_rd_data;
    logic                 cip_valid_in;
    logic [SRAMWIDTH-1:0] cip_data_in;
    logic                 cip_ready;
    logic                 cip_valid_out;
    logic [SRAMWIDTH-1:0] cip_data_out;
    logic                 out_wr_en;
    logic [ADDRSIZE-1:0]  out_wr_addr;
    logic [SRAMWIDTH-1:0] out_wr_data;

    modport master (
        output in_rd_en, in_rd_addr,
        input  in_rd_data,
        output cip_valid_in, cip_data_in,
        input  cip_ready, cip_valid_out, cip_data_out,
        output out_wr_en, out_wr_addr, out_wr_data
    );

    modport slave (
        input  in_rd_en, in_rd_addr,
        output in_rd_data,
        input  cip_valid_in, cip_data_in,
        output cip_ready, cip_valid_out, cip_data_out,
        input  out_wr_en, out_wr_addr, out_wr_data
    );
endinterface

// File: rtl/des_block_scheduler.sv
`timescale 1ns/1ps
// Streams num_blocks words input SRAM -> cipher -> output SRAM with a bounded in-flight count.
// Define DES_SCHED_STALL_CNT_EN to build the cipher backpressure stall counter.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing SRAM reads, collecting results
// DRAIN | all reads issued, waiting for remaining results
// DONE  | one-cycle completion pulse
module des_block_scheduler #(
    parameter int ADDRSIZE     = 14,
    parameter int SRAMWIDTH    = 64,
    parameter int BASE_ADDR    = 1,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDRSIZE-1:0] num_blocks,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         stall_cycles,
    des_block_scheduler_if.master bus
);
    localparam logic [ADDRSIZE-1:0] BASE   = ADDRSIZE'(BASE_ADDR);
    localparam logic [3:0]          MAX_IF = 4'(MAX_INFLIGHT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t               state;
    logic [ADDRSIZE-1:0]  nb_reg;
    logic [ADDRSIZE-1:0]  rd_cnt;
    logic [ADDRSIZE-1:0]  wr_cnt;
    logic [3:0]           inflight;
    logic                 rd_pending;
    logic [1:0]           hold_cnt;
    logic [SRAMWIDTH-1:0] hold0;
    logic [SRAMWIDTH-1:0] hold1;
    logic                 hold_rd_ptr;
    logic                 hold_wr_ptr;
    logic                 drop_late;
    logic                 wr_en_q;
    logic [ADDRSIZE-1:0]  wr_addr_q;
    logic [SRAMWIDTH-1:0] wr_data_q;

    logic                 run_act;
    logic                 start_ok;
    logic                 hold_pop;
    logic [2:0]           occ_next;
    logic                 rd_issue;
    logic                 res_ok;
    logic                 res_bad;

    always_comb begin
        run_act  = (state == S_RUN) || (state == S_DRAIN);
        start_ok = start && !abort && (state == S_IDLE);
        hold_pop = (hold_cnt != 2'd0) && bus.cip_ready;
        // Occupancy once this cycle's pop and pending capture settle; a read issued now
        // lands a cycle later, so it needs a free slot even if nothing drains meanwhile.
        occ_next = {1'b0, hold_cnt} + {2'b00, rd_pending} - {2'b00, hold_pop};
        rd_issue = (state == S_RUN) && !abort && (rd_cnt < nb_reg) &&
                   (inflight < MAX_IF) && (occ_next < 3'd2);
        res_ok   = bus.cip_valid_out && run_act && (inflight != 4'd0) && !abort;
        res_bad  = bus.cip_valid_out && !(run_act && (inflight != 4'd0)) &&
                   !abort && !drop_late;
    end

    assign bus.in_rd_en     = rd_issue;
    assign bus.in_rd_addr   = rd_issue ? (BASE + rd_cnt) : '0;
    assign bus.cip_valid_in = (hold_cnt != 2'd0);
    assign bus.cip_data_in  = (hold_cnt == 2'd0) ? '0 : (hold_rd_ptr ? hold1 : hold0);
    assign bus.out_wr_en    = wr_en_q;
    assign bus.out_wr_addr  = wr_addr_q;
    assign bus.out_wr_data  = wr_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            nb_reg      <= '0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            inflight    <= 4'd0;
            rd_pending  <= 1'b0;
            hold_cnt    <= 2'd0;
            hold0       <= '0;
            hold1       <= '0;
            hold_rd_ptr <= 1'b0;
            hold_wr_ptr <= 1'b0;
            drop_late   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else if (abort) begin
            // Results still inside the cipher belong to the cancelled run; swallow them quietly.
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_cnt      <= '0;
            wr_cnt      <= '0;
            inflight    <= 4'd0;
            rd_pending  <= 1'b0;
            hold_cnt    <= 2'd0;
            hold_rd_ptr <= 1'b0;
            hold_wr_ptr <= 1'b0;
            wr_en_q     <= 1'b0;
            drop_late   <= 1'b1;
        end else begin
            done       <= 1'b0;
            wr_en_q    <= 1'b0;
            rd_pending <= rd_issue;

            if (rd_issue)
                rd_cnt <= rd_cnt + ADDRSIZE'(1);

            if (rd_issue && !res_ok)
                inflight <= inflight + 4'd1;
            else if (!rd_issue && res_ok)
                inflight <= inflight - 4'd1;

            if (rd_pending) begin
                if (hold_wr_ptr)
                    hold1 <= bus.in_rd_data;
                else
                    hold0 <= bus.in_rd_data;
                hold_wr_ptr <= !hold_wr_ptr;
            end
            if (hold_pop)
                hold_rd_ptr <= !hold_rd_ptr;
            hold_cnt <= hold_cnt + {1'b0, rd_pending} - {1'b0, hold_pop};

            if (res_ok) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= BASE + wr_cnt;
                wr_data_q <= bus.cip_data_out;
                wr_cnt    <= wr_cnt + ADDRSIZE'(1);
            end

            if (res_bad)
                err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        err       <= 1'b0;
                        drop_late <= 1'b0;
                        nb_reg    <= num_blocks;
                        rd_cnt    <= '0;
                        wr_cnt    <= '0;
                        inflight  <= 4'd0;
                        if (num_blocks == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (rd_cnt == nb_reg)
                        state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (wr_cnt == nb_reg) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DES_SCHED_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_q <= '0;
        else if (start_ok)
            stall_q <= '0;
        else if (run_act && bus.cip_valid_in && !bus.cip_ready && (stall_q != 32'hFFFF_FFFF))
            stall_q <= stall_q + 32'd1;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_des_block_scheduler.sv
`timescale 1ns/1ps
// Scoreboard bench for des_block_scheduler: bench SRAM + fixed-latency cipher model,
// expected writes queued at read issue and popped on output SRAM writes.
module tb_des_block_scheduler;
    localparam int AW = 14;
    localparam int DW = 64;
    localparam logic [AW-1:0] BASE = 14'd1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] num_blocks = '0;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   stall_cycles;

    des_block_scheduler_if #(.ADDRSIZE(AW), .SRAMWIDTH(DW)) bus ();

    des_block_scheduler #(
        .ADDRSIZE(AW), .SRAMWIDTH(DW), .BASE_ADDR(1), .MAX_INFLIGHT(4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .num_blocks   (num_blocks),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .stall_cycles (stall_cycles),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {16'hC0DE, 2'b00, a, 18'h2AAAA, a};
    endfunction

    function automatic logic [DW-1:0] cipf(input logic [DW-1:0] d);
        return {d[31:0], d[63:32]} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // bench SRAM and cipher
    int           lat = 3;
    logic         rdy = 1'b1;
    logic         inj = 1'b0;
    logic         pv [16];
    logic [DW-1:0] pd [16];

    assign bus.cip_ready     = rdy;
    assign bus.cip_valid_out = pv[0] | inj;
    assign bus.cip_data_out  = pd[0];

    always @(posedge clk) begin
        if (bus.in_rd_en)
            bus.in_rd_data <= memf(bus.in_rd_addr);
    end

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                pv[i] <= 1'b0;
                pd[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 15; i++) begin
                pv[i] <= pv[i+1];
                pd[i] <= pd[i+1];
            end
            pv[15] <= 1'b0;
            if (bus.cip_valid_in && bus.cip_ready) begin
                pv[lat-1] <= 1'b1;
                pd[lat-1] <= cipf(bus.cip_data_in);
            end
        end
    end

    // scoreboard / monitors
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    logic [AW-1:0] ea;
    int cyc = 0;
    int rd_k = 0;
    int wr_seen = 0;
    int done_cnt = 0;
    int gap_cnt = 0;
    int last_rd = 0;
    int infl = 0;
    int infl_max = 0;
    int tot_rd = 0;
    int tot_wr = 0;
    int tot_vin = 0;
    logic no_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.in_rd_en) begin
                ea = BASE + AW'(rd_k);
                chk("rd_addr", 64'(bus.in_rd_addr), 64'(ea));
                exp_q.push_back('{a: ea, d: cipf(memf(ea))});
                if (rd_k > 0 && cyc != last_rd + 1)
                    gap_cnt++;
                last_rd = cyc;
                rd_k++;
                tot_rd++;
            end
            if (bus.cip_valid_in)
                tot_vin++;
            infl = infl + (bus.in_rd_en ? 1 : 0) - (pv[0] ? 1 : 0);
            if (infl > infl_max)
                infl_max = infl;
            if (no_wr) begin
                chk("no_wr", 64'(bus.out_wr_en), 64'(0));
            end else if (bus.out_wr_en) begin
                tot_wr++;
                wr_seen++;
                if (exp_q.size() == 0) begin
                    chk("wr_unexpected", 64'(bus.out_wr_en), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(bus.out_wr_addr), 64'(e.a));
                    chk("wr_data", bus.out_wr_data, e.d);
                end
            end
            if (done)
                done_cnt++;
        end
    end

    task automatic run_job(input int n, input int l, output int waited);
        bit got;
        lat = l;
        rd_k = 0;
        wr_seen = 0;
        gap_cnt = 0;
        infl = 0;
        infl_max = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_blocks = AW'(n);
        @(posedge clk); #1;
        start = 1'b0;
        num_blocks = '1;
        waited = 0;
        got = 1'b0;
        while (!got && waited < 2000) begin
            @(negedge clk);
            waited++;
            if (done)
                got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'(1));
        if (got) begin
            chk("busy_at_done", 64'(busy), 64'(0));
            chk("wr_count", 64'(wr_seen), 64'(n));
            chk("sb_empty", 64'(exp_q.size()), 64'(0));
            @(negedge clk);
            chk("done_1cyc", 64'(done), 64'(0));
            chk("busy_after", 64'(busy), 64'(0));
        end
    endtask

    task automatic stall_seq();
        int  k = 0;
        bit  seen = 1'b0;
        while (!seen && k < 300) begin
            @(posedge clk); #1;
            k++;
            if (bus.cip_valid_in && rd_k >= 2)
                seen = 1'b1;
        end
        chk("stall_window", 64'(seen), 64'(1));
        if (seen) begin
            rdy = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("vin_held", 64'(bus.cip_valid_in), 64'(1));
                if (i >= 2)
                    chk("rd_while_full", 64'(bus.in_rd_en), 64'(0));
                @(posedge clk);
            end
            #1 rdy = 1'b1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int d0;
        int r0;
        int wr0;
        int v0;
        int k;
        logic [31:0] exp_stall;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_rd_en", 64'(bus.in_rd_en), 64'(0));
        chk("rst_rd_addr", 64'(bus.in_rd_addr), 64'(0));
        chk("rst_vin", 64'(bus.cip_valid_in), 64'(0));
        chk("rst_wr_en", 64'(bus.out_wr_en), 64'(0));
        chk("rst_wr_addr", 64'(bus.out_wr_addr), 64'(0));
        chk("rst_stall", 64'(stall_cycles), 64'(0));

        // T1: 4 blocks, short cipher
        d0 = done_cnt;
        run_job(4, 3, w);
        chk("t1_consecutive_reads", 64'(gap_cnt), 64'(0));
        chk("t1_reads", 64'(rd_k), 64'(4));
        chk("t1_done_pulses", 64'(done_cnt - d0), 64'(1));
        chk("t1_err", 64'(err), 64'(0));

        // T2: in-flight bound under long cipher latency
        run_job(8, 10, w);
        chk("t2_inflight_max", 64'(infl_max), 64'(4));
        chk("t2_reads", 64'(rd_k), 64'(8));

        // T3: cipher backpressure
        fork
            run_job(8, 3, w);
            stall_seq();
        join
`ifdef DES_SCHED_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        chk("t3_stall_cycles", 64'(stall_cycles), 64'(exp_stall));

        // T4: zero-length run
        r0 = tot_rd;
        wr0 = tot_wr;
        v0 = tot_vin;
        run_job(0, 3, w);
        chk("t4_done_latency", 64'(w), 64'(1));
        chk("t4_no_reads", 64'(tot_rd - r0), 64'(0));
        chk("t4_no_writes", 64'(tot_wr - wr0), 64'(0));
        chk("t4_no_cipher", 64'(tot_vin - v0), 64'(0));

        // T5: abort mid-run, then a clean rerun
        lat = 3;
        rd_k = 0;
        @(posedge clk); #1;
        start = 1'b1;
        num_blocks = 14'd6;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (rd_k < 3 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reads_reached", 64'(rd_k >= 3), 64'(1));
        d0 = done_cnt;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        no_wr = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("t5_busy_after_abort", 64'(busy), 64'(0));
        chk("t5_vin_flushed", 64'(bus.cip_valid_in), 64'(0));
        repeat (20) @(negedge clk);
        chk("t5_err_late", 64'(err), 64'(0));
        chk("t5_no_done", 64'(done_cnt - d0), 64'(0));
        no_wr = 1'b0;
        run_job(6, 3, w);
        chk("t5_rerun_reads", 64'(rd_k), 64'(6));

        // T6: stray result while idle
        no_wr = 1'b1;
        @(posedge clk); #1 inj = 1'b1;
        @(posedge clk); #1 inj = 1'b0;
        @(negedge clk);
        chk("t6_err_set", 64'(err), 64'(1));
        repeat (3) @(negedge clk);
        chk("t6_err_sticky", 64'(err), 64'(1));
        no_wr = 1'b0;
        run_job(2, 3, w);
        chk("t6_err_cleared", 64'(err), 64'(0));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
